// File: rtl/bridge_arbiter_2to1.sv
// Two-port arbiter in front of the 32-to-16 SDRAM bridge. It grants one whole
// transaction at a time and returns completion and read data to the owner only.
module bridge_arbiter_2to1 #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_cs,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  input  logic        p0_wr_en,
  input  logic [3:0]  p0_bytesel,
  output logic        p0_compl,

  input  logic        p1_cs,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  input  logic        p1_wr_en,
  input  logic [3:0]  p1_bytesel,
  output logic        p1_compl,

  output logic        m_cs,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        m_wr_en,
  output logic [3:0]  m_bytesel,
  input  logic        m_compl,

  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   lastOwner_q, lastOwner_d;
  logic   req0, req1, pick1;

  // A chip select with no byte lanes enabled is not a real request.
  assign req0 = p0_cs && (|p0_bytesel);
  assign req1 = p1_cs && (|p1_bytesel);

  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    pick1       = 1'b0;

    if (req0 && req1) begin
      pick1 = FIXED_PRIORITY ? 1'b0 : ~lastOwner_q;
    end else begin
      pick1 = req1;
    end

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d     = pick1 ? OWN1 : OWN0;
          lastOwner_d = pick1;
        end
      end
      OWN0, OWN1: begin
        if (m_compl) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
    end
  end

  // m_cs and grant come from the state register alone, so a new request
  // never reaches the bridge combinationally.
  always_comb begin
    m_cs      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wr_en   = 1'b0;
    m_bytesel = '0;
    grant     = 2'b00;
    busy      = 1'b0;
    p0_compl  = 1'b0;
    p0_rdata  = '0;
    p1_compl  = 1'b0;
    p1_rdata  = '0;

    case (state_q)
      OWN0: begin
        m_cs      = 1'b1;
        m_addr    = p0_addr;
        m_wdata   = p0_wdata;
        m_wr_en   = p0_wr_en;
        m_bytesel = p0_bytesel;
        grant     = 2'b01;
        busy      = 1'b1;
        p0_compl  = m_compl;
        p0_rdata  = m_rdata;
      end
      OWN1: begin
        m_cs      = 1'b1;
        m_addr    = p1_addr;
        m_wdata   = p1_wdata;
        m_wr_en   = p1_wr_en;
        m_bytesel = p1_bytesel;
        grant     = 2'b10;
        busy      = 1'b1;
        p1_compl  = m_compl;
        p1_rdata  = m_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bridge_arbiter_2to1.sv
// Directed bench for bridge_arbiter_2to1: instance 0 is round-robin, instance 1
// is fixed-priority, each with its own small bridge model answering after 4 cycles.
module tb_bridge_arbiter_2to1;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        cs      [2][2];
  logic [31:0] addr    [2][2];
  logic [31:0] wdata   [2][2];
  logic        wrEn    [2][2];
  logic [3:0]  bytesel [2][2];
  logic [31:0] rdata   [2][2];
  logic        compl   [2][2];

  logic        mCs      [2];
  logic [31:0] mAddr    [2];
  logic [31:0] mWdata   [2];
  logic        mWrEn    [2];
  logic [3:0]  mBytesel [2];
  logic        mCompl   [2];
  logic [1:0]  grant    [2];
  logic        busy     [2];

  logic        modelCompl [2];
  logic [2:0]  modelCnt   [2];
  logic        injCompl   [2];
  logic [31:0] rdataVal;

  int checksTotal;
  int checksPassed;
  int checksFailed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bridge_arbiter_2to1 #(.FIXED_PRIORITY(1'b0)) dutRr (
    .clk(clk), .rst(rst),
    .p0_cs(cs[0][0]), .p0_addr(addr[0][0]), .p0_wdata(wdata[0][0]), .p0_rdata(rdata[0][0]),
    .p0_wr_en(wrEn[0][0]), .p0_bytesel(bytesel[0][0]), .p0_compl(compl[0][0]),
    .p1_cs(cs[0][1]), .p1_addr(addr[0][1]), .p1_wdata(wdata[0][1]), .p1_rdata(rdata[0][1]),
    .p1_wr_en(wrEn[0][1]), .p1_bytesel(bytesel[0][1]), .p1_compl(compl[0][1]),
    .m_cs(mCs[0]), .m_addr(mAddr[0]), .m_wdata(mWdata[0]), .m_rdata(rdataVal),
    .m_wr_en(mWrEn[0]), .m_bytesel(mBytesel[0]), .m_compl(mCompl[0]),
    .grant(grant[0]), .busy(busy[0])
  );

  bridge_arbiter_2to1 #(.FIXED_PRIORITY(1'b1)) dutFp (
    .clk(clk), .rst(rst),
    .p0_cs(cs[1][0]), .p0_addr(addr[1][0]), .p0_wdata(wdata[1][0]), .p0_rdata(rdata[1][0]),
    .p0_wr_en(wrEn[1][0]), .p0_bytesel(bytesel[1][0]), .p0_compl(compl[1][0]),
    .p1_cs(cs[1][1]), .p1_addr(addr[1][1]), .p1_wdata(wdata[1][1]), .p1_rdata(rdata[1][1]),
    .p1_wr_en(wrEn[1][1]), .p1_bytesel(bytesel[1][1]), .p1_compl(compl[1][1]),
    .m_cs(mCs[1]), .m_addr(mAddr[1]), .m_wdata(mWdata[1]), .m_rdata(rdataVal),
    .m_wr_en(mWrEn[1]), .m_bytesel(mBytesel[1]), .m_compl(mCompl[1]),
    .grant(grant[1]), .busy(busy[1])
  );

  assign mCompl[0] = modelCompl[0] | injCompl[0];
  assign mCompl[1] = modelCompl[1] | injCompl[1];

  // Bridge model: completes LAT cycles after it first sees m_cs, then idles one cycle.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        modelCompl[d] <= 1'b0;
        modelCnt[d]   <= '0;
      end else if (mCs[d] && !modelCompl[d]) begin
        if (modelCnt[d] == 3'(LAT - 1)) begin
          modelCompl[d] <= 1'b1;
          modelCnt[d]   <= '0;
        end else begin
          modelCnt[d] <= modelCnt[d] + 3'd1;
        end
      end else begin
        modelCompl[d] <= 1'b0;
        modelCnt[d]   <= '0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input int p, input logic c, input logic w,
                               input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bs);
    cs[d][p]      = c;
    wrEn[d][p]    = w;
    addr[d][p]    = a;
    wdata[d][p]   = wd;
    bytesel[d][p] = bs;
  endtask

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checksTotal++;
    assert (observed === expected) begin
      checksPassed++;
    end else begin
      checksFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitGrant(input int d);
    for (int i = 0; i < 10; i++) begin
      if (grant[d] != 2'b00) break;
      tick();
    end
  endtask

  task automatic waitCompl(input int d, input int p, output int cycles, output logic found);
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (compl[d][p] === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc;
    logic        found;
    logic [1:0]  expGrant;
    logic [31:0] expAddr;

    checksTotal  = 0;
    checksPassed = 0;
    checksFailed = 0;
    rst          = 1'b1;
    rdataVal     = 32'h0;
    for (int d = 0; d < 2; d++) begin
      injCompl[d] = 1'b0;
      for (int p = 0; p < 2; p++) applyStimulus(d, p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    repeat (2) tick();
    rst = 1'b0;

    // Reset state of both instances.
    checkOutput("resetRr", {mCs[0], grant[0], busy[0], mAddr[0], mWdata[0], mWrEn[0], mBytesel[0]}, 96'h0);
    checkOutput("resetFp", {mCs[1], grant[1], busy[1], mAddr[1], mWdata[1], mWrEn[1], mBytesel[1]}, 96'h0);
    checkOutput("resetCompl", {compl[0][0], compl[0][1], compl[1][0], compl[1][1]}, 96'h0);

    // Single read from port 0.
    rdataVal = 32'hDEADBEEF;
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    #1;
    checkOutput("readNoCombCs", 96'(mCs[0]), 96'h0);
    tick();
    checkOutput("readGrantLatency", {mCs[0], grant[0], busy[0]}, {1'b1, 2'b01, 1'b1});
    checkOutput("readAddr", 96'(mAddr[0]), 96'h100);
    waitCompl(0, 0, cyc, found);
    checkOutput("readComplSeen", 96'(found), 96'h1);
    checkOutput("readLatency", 96'(cyc), 96'(LAT));
    checkOutput("readRdata", 96'(rdata[0][0]), 96'hDEADBEEF);
    checkOutput("readOtherCompl", {compl[0][1], rdata[0][1]}, 96'h0);
    tick();
    checkOutput("readCsDrop", {mCs[0], grant[0], compl[0][0]}, 96'h0);
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Round-robin under continuous requests from both ports.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF);
    applyStimulus(0, 1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      expGrant = (k % 2 == 0) ? 2'b01 : 2'b10;
      expAddr  = (k % 2 == 0) ? 32'h1000 : 32'h2000;
      waitGrant(0);
      checkOutput($sformatf("rrGrant%0d", k), 96'(grant[0]), 96'(expGrant));
      checkOutput($sformatf("rrAddr%0d", k), 96'(mAddr[0]), 96'(expAddr));
      waitCompl(0, (k % 2 == 0) ? 0 : 1, cyc, found);
      checkOutput($sformatf("rrCompl%0d", k), 96'(found), 96'h1);
      tick();
      checkOutput($sformatf("rrTurnaround%0d", k), {mCs[0], grant[0]}, 96'h0);
    end
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Fixed priority: three back-to-back port 0 transactions beat port 1.
    rdataVal = 32'hA5A5_0F0F;
    applyStimulus(1, 0, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF);
    applyStimulus(1, 1, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      expGrant = (k < 3) ? 2'b01 : 2'b10;
      expAddr  = (k < 3) ? 32'h4000 : 32'h3000;
      waitGrant(1);
      checkOutput($sformatf("fpGrant%0d", k), 96'(grant[1]), 96'(expGrant));
      checkOutput($sformatf("fpAddr%0d", k), 96'(mAddr[1]), 96'(expAddr));
      waitCompl(1, (k < 3) ? 0 : 1, cyc, found);
      checkOutput($sformatf("fpCompl%0d", k), 96'(found), 96'h1);
      checkOutput($sformatf("fpRdata%0d", k), 96'(rdata[1][(k < 3) ? 0 : 1]), 96'(rdataVal));
      tick();
      checkOutput($sformatf("fpTurnaround%0d", k), {mCs[1], grant[1]}, 96'h0);
      if (k == 2) applyStimulus(1, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    applyStimulus(1, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Write routing from port 1 while port 0 is idle.
    rdataVal = 32'hCAFEF00D;
    applyStimulus(0, 1, 1'b1, 1'b1, 32'h2004, 32'h12345678, 4'hC);
    tick();
    checkOutput("wrGrant", 96'(grant[0]), 96'(2'b10));
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("wrMirror%0d", i), {mAddr[0], mWdata[0], mWrEn[0], mBytesel[0]},
                  {32'h2004, 32'h12345678, 1'b1, 4'hC});
      if (compl[0][1] === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("wrComplSeen", 96'(found), 96'h1);
    checkOutput("wrRdataOwner", 96'(rdata[0][1]), 96'hCAFEF00D);
    checkOutput("wrNonOwner", {compl[0][0], rdata[0][0]}, 96'h0);
    tick();
    checkOutput("wrPulseOneCycle", {compl[0][1], mCs[0]}, 96'h0);
    applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Chip select without byte lanes is ignored.
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("noReq%0d", i), {mCs[0], grant[0]}, 96'h0);
    end
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset in the middle of a port 1 transaction.
    applyStimulus(0, 1, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
    tick();
    checkOutput("midGrant", 96'(grant[0]), 96'(2'b10));
    rst = 1'b1;
    tick();
    checkOutput("midReset", {mCs[0], grant[0], busy[0]}, 96'h0);
    applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    tick();

    // Spurious completion while idle.
    injCompl[0] = 1'b1;
    #1;
    checkOutput("spurCompl", {compl[0][0], compl[0][1]}, 96'h0);
    tick();
    checkOutput("spurIdle", {mCs[0], grant[0]}, 96'h0);
    injCompl[0] = 1'b0;

    // Leave last owner at port 0, then reset: a tie must still go to port 0.
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
    tick();
    checkOutput("preGrant", 96'(grant[0]), 96'(2'b01));
    waitCompl(0, 0, cyc, found);
    checkOutput("preComplSeen", 96'(found), 96'h1);
    tick();
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF);
    applyStimulus(0, 1, 1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
    tick();
    checkOutput("tieAfterReset", 96'(grant[0]), 96'(2'b01));
    waitCompl(0, 0, cyc, found);
    checkOutput("tieComplSeen", 96'(found), 96'h1);
    tick();
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/bridge_arbiter_2to1.md
Name: bridge_arbiter_2to1

Overview:
- Shares one 32-bit bridge host port (cs/addr/wdata/rdata/wr_en/bytesel/compl) between two 32-bit requesters, port 0 and port 1 (e.g. instruction and data buses).
- Sits directly in front of the 32-to-16 bridge feeding the SDRAM controller.
- Grants one whole transaction at a time and routes completion and read data back to the owner only.
- Supports round-robin or fixed-priority arbitration.

Parameters:
- FIXED_PRIORITY, default 0. 0 = round-robin. 1 = port 0 always wins simultaneous requests.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p0_cs  in  1  port 0 chip select
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data
- p0_rdata  out  32  port 0 read data, valid when p0_compl=1
- p0_wr_en  in  1  port 0 write (1) / read (0)
- p0_bytesel  in  4  port 0 byte lanes
- p0_compl  out  1  port 0 single-cycle completion pulse
- p1_cs, p1_addr, p1_wdata, p1_rdata, p1_wr_en, p1_bytesel, p1_compl: same as port 0, for port 1
- m_cs  out  1  to bridge h_cs
- m_addr  out  32  to bridge h_addr
- m_wdata  out  32  to bridge h_wdata
- m_rdata  in  32  from bridge h_rdata
- m_wr_en  out  1  to bridge h_wr_en
- m_bytesel  out  4  to bridge h_bytesel
- m_compl  in  1  from bridge h_compl
- grant  out  2  one-hot current owner, 00 when idle
- busy  out  1  high while a transaction is granted

Behaviour:
- Request definition: pN_cs && |pN_bytesel. cs with bytesel=0000 is not a request.
- Requester protocol: the requester holds cs/addr/wdata/wr_en/bytesel stable from assertion until it sees pN_compl, then drops cs or presents a new request the following cycle.
- States: IDLE, OWN0, OWN1. All state is registered. Downstream outputs decode combinationally from the state register only, so there is no request-to-m_cs combinational path.
- IDLE:
  - m_cs=0, m_addr=0, m_wdata=0, m_wr_en=0, m_bytesel=0, grant=00, busy=0.
  - On an edge with at least one request, go to OWN0 or OWN1. m_cs rises the cycle after the request is first sampled (1-cycle grant latency).
- OWNn:
  - m_* mirror pN_* of the owner, with m_cs=1. grant[n]=1, busy=1.
  - When m_compl=1: pN_compl=1 and pN_rdata=m_rdata, same cycle (pass-through). State returns to IDLE on that edge, so m_cs is low the cycle after compl.
  - The bridge is therefore always idle for at least one cycle with m_cs=0 between transactions.
- Non-owner: pN_compl=0 and pN_rdata=0 at all times.
- Arbitration, round-robin (FIXED_PRIORITY=0):
  - last_owner register, reset to 1.
  - When both request in IDLE, grant the port != last_owner.
  - A single requester is granted immediately regardless of last_owner.
  - last_owner updates on entry to OWNn.
- Arbitration, fixed (FIXED_PRIORITY=1): port 0 wins every tie.
  - Port 1 can starve; this is an accepted property of the mode.
- No pre-emption: a granted transaction runs to m_compl. Request changes on the non-owner during OWNn are ignored until IDLE.
- A request withdrawn mid-transaction is a protocol violation; behaviour is undefined and the arbiter keeps ownership until m_compl.
- m_compl received in IDLE (spurious, or left over after reset) is ignored: no pN_compl is generated.
- Reset, synchronous: state=IDLE, last_owner=1, all outputs as in IDLE, from the cycle after rst is sampled high.
  - Reset mid-transaction drops the grant immediately. The system must reset the bridge simultaneously or assert rst only while busy=0.
- Throughput: back-to-back transactions from alternating ports cost bridge latency + 2 cycles each (1 grant + 1 turnaround).

Test Plan:
- Single read: p0 read of addr 0x100, bytesel=1111. Bridge model returns 0xDEADBEEF with m_compl after 4 cycles -> m_cs rises 1 cycle after request; p0_compl=1 with p0_rdata=0xDEADBEEF; p1_compl stays 0; m_cs=0 the next cycle.
- Simultaneous requests, round-robin: after reset, both ports request continuously -> grant sequence 01,10,01,10; each grant separated by one idle cycle with grant=00.
- Simultaneous requests, FIXED_PRIORITY=1: p0 requests 3 back-to-back, p1 requests throughout -> all three p0 transactions granted before p1; p1 granted after p0 drops cs.
- Write routing: p1 write addr 0x2004, wdata 0x12345678, bytesel=1100, while p0 is idle -> m_addr=0x2004, m_wdata=0x12345678, m_wr_en=1, m_bytesel=1100 for the whole grant; p1_compl pulses for exactly 1 cycle.
- Non-request: p0_cs=1 with bytesel=0000 for 10 cycles -> m_cs stays 0, grant=00.
- Reset and spurious completion: rst asserted while OWN1 -> next cycle m_cs=0, grant=00. An m_compl pulse injected in IDLE produces no p0_compl or p1_compl. After reset, a tie grants port 0 first.
